alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered ALU instance (WIDTH-bit operands, 3-bit select, 2*WIDTH result, registered on clk when enabled) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin.
- The block sequences the ALU's one-cycle registered latency, captures the result and compare flags, and returns them to the granted requester.
- Divide-by-zero is trapped without issuing to the ALU.

Parameters:
WIDTH, 4, operand width; result width is 2*WIDTH.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 request accepted this cycle
req0_a  in  WIDTH  requester 0 operand a
req0_b  in  WIDTH  requester 0 operand b
req0_op  in  3  requester 0 ALU select code
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
resp0_valid  out  1  response for requester 0 available
resp0_ready  in  1  requester 0 takes response
resp1_valid  out  1  response for requester 1 available
resp1_ready  in  1  requester 1 takes response
resp_data  out  2*WIDTH  captured result, shared by both response channels
resp_flags  out  4  {div0, a_greater, a_equal, a_less}
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b
alu_select  out  3  ALU select
alu_enable  out  1  ALU enable
alu_out  in  2*WIDTH  ALU registered result
alu_a_greater, alu_a_equal, alu_a_less  in  1 each  ALU combinational compare flags

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: ready, valid, resp_data, resp_flags, alu_a, alu_b, alu_select, alu_enable.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first tie.
- Reset mid-operation: any in-flight operation or pending response is discarded, with no response delivered.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is combinational.
    - If only one reqN_valid is high, grant that requester.
    - If both are high, grant the requester other than last_grant.
  - reqN_ready = 1 only for the granted requester, only in IDLE. Both are 0 in every other state.
  - On the handshake edge:
    - Register a, b and op into alu_a, alu_b, alu_select.
    - Record the owner and set last_grant = owner.
    - If op == 3'b111 and b == 0, go to RESP with resp_data = all ones, resp_flags = 4'b1000, and never assert alu_enable.
    - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_enable = 1; alu_a, alu_b and alu_select are held stable.
  - On the edge: capture {0, alu_a_greater, alu_a_equal, alu_a_less} into resp_flags, then go to WAIT.
- WAIT (exactly 1 cycle):
  - alu_enable = 0. alu_out now holds the result registered at the ISSUE edge.
  - On the edge: capture alu_out into resp_data, then go to RESP.
- RESP:
  - respN_valid = 1 for the owner only.
  - resp_data and resp_flags are held stable until the response is taken.
  - On respN_valid & respN_ready: clear respN_valid and go to IDLE. A new grant is possible on the next cycle, not the same one.
- Latency: handshake at edge T gives respN_valid high after edge T+2, i.e. 2 cycles after acceptance. The div0 trap gives valid after edge T.
- Throughput: at most one operation in flight; the next acceptance comes no earlier than 1 cycle after the response is taken.
- alu_a, alu_b and alu_select hold their last values outside ISSUE.
- alu_enable is high only in ISSUE.
- Requests are not buffered. An unaccepted requester must hold valid and its payload until ready.
- Valid dropped before ready is legal; the request is not recorded.
- respN_ready for a non-owner is ignored.
- last_grant updates only on an accepted handshake.

Test Plan:
- Reset, then req0 a=9 b=8 op=000 with resp0_ready=1 -> req0_ready in the cycle after reset deassert; alu_enable pulses 1 cycle; resp0_valid 2 cycles after acceptance; resp_data=8'h11; flags=4'b0100. resp1_valid stays 0.
- req1 a=15 b=15 op=110 -> resp1 resp_data=8'hE1, flags=4'b0010 (equal).
- Both valid continuously for 4 ops, after reset -> grant order 0,1,0,1; each requester gets exactly 2 responses; no two responses overlap.
- req0 a=7 b=0 op=111 -> alu_enable never high; resp0_valid after 1 cycle; resp_data=8'hFF; flags[3]=1.
- Backpressure: resp0_ready held low 5 cycles during RESP with req1_valid high -> resp0_valid, resp_data and flags stable; req0_ready=req1_ready=0. After resp0_ready, req1 is granted the next cycle.
- Assert rst_n low during WAIT of a req0 op -> all outputs 0 immediately; no resp0_valid after release; the next req1 a=3 b=5 op=001 completes normally with the ALU's subtract result.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU-side signals of the two-requester ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 4
);
    logic               req0_valid;
    logic               req0_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic [2:0]         req0_op;
    logic               req1_valid;
    logic               req1_ready;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic [2:0]         req1_op;
    logic               resp0_valid;
    logic               resp0_ready;
    logic               resp1_valid;
    logic               resp1_ready;
    logic [2*WIDTH-1:0] resp_data;
    logic [3:0]         resp_flags;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [2:0]         alu_select;
    logic               alu_enable;
    logic [2*WIDTH-1:0] alu_out;
    logic               alu_a_greater;
    logic               alu_a_equal;
    logic               alu_a_less;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  resp0_ready, resp1_ready,
        input  alu_out, alu_a_greater, alu_a_equal, alu_a_less,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, resp_flags,
        output alu_a, alu_b, alu_select, alu_enable
    );

    // Requesters plus the ALU itself.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output resp0_ready, resp1_ready,
        output alu_out, alu_a_greater, alu_a_equal, alu_a_less,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, resp_flags,
        input  alu_a, alu_b, alu_select, alu_enable
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered ALU between two requesters
// Sequences issue/wait around the ALU latency and traps divide-by-zero locally.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_last_grant;
    logic               r_owner;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2:0]         r_alu_sel;
    logic [2*WIDTH-1:0] r_resp_data;
    logic [3:0]         r_resp_flags;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic               w_div0;
    logic               w_resp_take;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [2:0]         w_op;
    logic               w_req0_ready;
    logic               w_req1_ready;
    logic               w_resp0_valid;
    logic               w_resp1_valid;
    logic               w_alu_enable;

    // On a tie the requester that did not win last time goes first.
    assign w_grant0    = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_grant1    = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_accept    = (r_state == S_IDLE) && (w_grant0 || w_grant1);
    assign w_a         = w_grant1 ? bus.req1_a  : bus.req0_a;
    assign w_b         = w_grant1 ? bus.req1_b  : bus.req0_b;
    assign w_op        = w_grant1 ? bus.req1_op : bus.req0_op;
    assign w_div0      = (w_op == 3'b111) && (w_b == '0);
    assign w_resp_take = (r_state == S_RESP) && (r_owner ? bus.resp1_ready : bus.resp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_div0 ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = S_RESP;
            S_RESP:  if (w_resp_take) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ready is masked by rst_n so nothing is offered while reset is held.
    always_comb begin
        w_req0_ready  = rst_n && (r_state == S_IDLE) && w_grant0;
        w_req1_ready  = rst_n && (r_state == S_IDLE) && w_grant1;
        w_alu_enable  = (r_state == S_ISSUE);
        w_resp0_valid = (r_state == S_RESP) && !r_owner;
        w_resp1_valid = (r_state == S_RESP) && r_owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_a;
                r_alu_b      <= w_b;
                r_alu_sel    <= w_op;
                r_owner      <= w_grant1;
                r_last_grant <= w_grant1;
                if (w_div0) begin
                    r_resp_data  <= '1;
                    r_resp_flags <= 4'b1000;
                end
            end
            // Compare flags are combinational off the held operands; result lags by one cycle.
            if (r_state == S_ISSUE) begin
                r_resp_flags <= {1'b0, bus.alu_a_greater, bus.alu_a_equal, bus.alu_a_less};
            end
            if (r_state == S_WAIT) begin
                r_resp_data <= bus.alu_out;
            end
        end
    end

    assign bus.req0_ready  = w_req0_ready;
    assign bus.req1_ready  = w_req1_ready;
    assign bus.resp0_valid = w_resp0_valid;
    assign bus.resp1_valid = w_resp1_valid;
    assign bus.resp_data   = r_resp_data;
    assign bus.resp_flags  = r_resp_flags;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_select  = r_alu_sel;
    assign bus.alu_enable  = w_alu_enable;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level reference model
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus();
    alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [7:0] xa;
        logic [7:0] xb;
        xa = {4'b0, a};
        xb = {4'b0, b};
        case (op)
            3'd0:    return xa + xb;
            3'd1:    return xa - xb;
            3'd2:    return xa & xb;
            3'd3:    return xa | xb;
            3'd4:    return xa ^ xb;
            3'd5:    return xa << b[1:0];
            3'd6:    return xa * xb;
            default: return (b == 4'd0) ? 8'hFF : xa / xb;
        endcase
    endfunction

    // The shared ALU: result registered when enabled, compare flags combinational.
    always @(posedge clk) begin
        if (bus.alu_enable) bus.alu_out <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_select);
    end
    assign bus.alu_a_greater = bus.alu_a > bus.alu_b;
    assign bus.alu_a_equal   = bus.alu_a == bus.alu_b;
    assign bus.alu_a_less    = bus.alu_a < bus.alu_b;

    initial forever begin
        @(negedge clk);
        if (bus.alu_enable) en_cnt++;
    end

    // Reference model: one operation at a time, response ready a fixed number of edges after acceptance.
    initial begin
        logic m_busy, m_owner, m_last, m_div0;
        int m_age;
        logic [3:0] m_a, m_b;
        logic [2:0] m_op;
        logic [7:0] m_data;
        logic [3:0] m_flags;
        logic e_r0, e_r1, e_en, e_rv, tk;
        m_busy = 0; m_owner = 0; m_last = 1; m_div0 = 0; m_age = 0;
        m_a = 0; m_b = 0; m_op = 0; m_data = 0; m_flags = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_req0_ready", 32'(bus.req0_ready), 0);
                check("rst_req1_ready", 32'(bus.req1_ready), 0);
                check("rst_resp0_valid", 32'(bus.resp0_valid), 0);
                check("rst_resp1_valid", 32'(bus.resp1_valid), 0);
                check("rst_resp_data", 32'(bus.resp_data), 0);
                check("rst_resp_flags", 32'(bus.resp_flags), 0);
                check("rst_alu_a", 32'(bus.alu_a), 0);
                check("rst_alu_b", 32'(bus.alu_b), 0);
                check("rst_alu_select", 32'(bus.alu_select), 0);
                check("rst_alu_enable", 32'(bus.alu_enable), 0);
                m_busy = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0;
            end else begin
                e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
                e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
                e_en = m_busy && !m_div0 && (m_age == 1);
                e_rv = m_busy && (m_age >= (m_div0 ? 1 : 3));
                check("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
                check("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
                check("alu_enable", 32'(bus.alu_enable), 32'(e_en));
                check("resp0_valid", 32'(bus.resp0_valid), 32'(e_rv && !m_owner));
                check("resp1_valid", 32'(bus.resp1_valid), 32'(e_rv && m_owner));
                check("alu_a", 32'(bus.alu_a), 32'(m_a));
                check("alu_b", 32'(bus.alu_b), 32'(m_b));
                check("alu_select", 32'(bus.alu_select), 32'(m_op));
                if (e_rv) begin
                    check("resp_data", 32'(bus.resp_data), 32'(m_data));
                    check("resp_flags", 32'(bus.resp_flags), 32'(m_flags));
                end
                tk = m_owner ? bus.resp1_ready : bus.resp0_ready;
                if (e_r0 || e_r1) begin
                    m_a     = e_r1 ? bus.req1_a  : bus.req0_a;
                    m_b     = e_r1 ? bus.req1_b  : bus.req0_b;
                    m_op    = e_r1 ? bus.req1_op : bus.req0_op;
                    m_div0  = (m_op == 3'd7) && (m_b == 4'd0);
                    m_data  = m_div0 ? 8'hFF : alu_ref(m_a, m_b, m_op);
                    m_flags = m_div0 ? 4'b1000 : {1'b0, m_a > m_b, m_a == m_b, m_a < m_b};
                    m_owner = e_r1;
                    m_last  = e_r1;
                    m_busy  = 1;
                    m_age   = 0;
                end else if (e_rv && tk) begin
                    m_busy = 0;
                end
                if (m_busy) m_age++;
            end
        end
    end

    task automatic drive_req(input int who, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (who == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    function automatic logic rdy(input int who);
        return (who == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rvld(input int who);
        return (who == 0) ? bus.resp0_valid : bus.resp1_valid;
    endfunction

    // Starts and ends just after a rising edge.
    task automatic run_op(input int who, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          output logic [7:0] d, output logic [3:0] f, output int lat);
        int n;
        drive_req(who, 1'b1, a, b, op);
        if (who == 0) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy(who) && n < 50);
        check($sformatf("accept_req%0d", who), 32'(rdy(who)), 1);
        @(posedge clk); #1;
        drive_req(who, 1'b0, a, b, op);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rvld(who) && lat < 50);
        d = bus.resp_data;
        f = bus.resp_flags;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] f;
        int lat, e0, n, c0, c1, ovl, done;
        logic [3:0] seq;
        int order[$];
        logic a0, a1;

        drive_req(0, 1'b1, 4'd0, 4'd0, 3'd0);
        drive_req(1, 1'b0, 4'd0, 4'd0, 3'd0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_holds_ready_low", 32'(bus.req0_ready), 0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;

        e0 = en_cnt;
        run_op(0, 4'd9, 4'd8, 3'b000, d, f, lat);
        check("add_data", 32'(d), 32'h11);
        check("add_flags", 32'(f), 32'b0100);
        check("add_latency", 32'(lat), 3);
        check("add_enable_pulses", 32'(en_cnt - e0), 1);

        run_op(1, 4'd15, 4'd15, 3'b110, d, f, lat);
        check("mul_data", 32'(d), 32'hE1);
        check("mul_flags", 32'(f), 32'b0010);

        e0 = en_cnt;
        run_op(0, 4'd7, 4'd0, 3'b111, d, f, lat);
        check("div0_data", 32'(d), 32'hFF);
        check("div0_flags", 32'(f), 32'b1000);
        check("div0_latency", 32'(lat), 1);
        check("div0_no_enable", 32'(en_cnt - e0), 0);

        // Both requesters contend continuously after reset.
        pulse_reset();
        drive_req(0, 1'b1, 4'd1, 4'd2, 3'd0);
        drive_req(1, 1'b1, 4'd3, 4'd3, 3'd6);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        c0 = 0; c1 = 0; ovl = 0; n = 0;
        while (order.size() < 4 && n < 100) begin
            @(negedge clk); n++;
            if (bus.req0_ready) order.push_back(0);
            if (bus.req1_ready) order.push_back(1);
            c0 += int'(bus.resp0_valid);
            c1 += int'(bus.resp1_valid);
            if (bus.resp0_valid && bus.resp1_valid) ovl++;
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            c0 += int'(bus.resp0_valid);
            c1 += int'(bus.resp1_valid);
            if (bus.resp0_valid && bus.resp1_valid) ovl++;
            @(posedge clk); #1;
        end
        seq = 4'b0;
        foreach (order[i]) seq = {seq[2:0], order[i][0]};
        check("rr_grant_count", 32'(order.size()), 4);
        check("rr_grant_order", 32'(seq), 32'b0101);
        check("rr_resp0_count", 32'(c0), 2);
        check("rr_resp1_count", 32'(c1), 2);
        check("rr_no_overlap", 32'(ovl), 0);

        // Response backpressure with the other requester waiting.
        drive_req(0, 1'b1, 4'd5, 4'd3, 3'd0);
        bus.resp0_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req0_ready && n < 50);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 4'd5, 4'd3, 3'd0);
        drive_req(1, 1'b1, 4'd2, 4'd2, 3'd6);
        bus.resp1_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.resp0_valid && n < 50);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp0_valid", 32'(bus.resp0_valid), 1);
            check("bp_data", 32'(bus.resp_data), 32'h08);
            check("bp_flags", 32'(bus.resp_flags), 32'b0100);
            check("bp_req1_ready", 32'(bus.req1_ready), 0);
            @(posedge clk); #1;
            if (i == 4) bus.resp0_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("bp_req1_granted_next", 32'(bus.req1_ready), 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.resp1_valid && n < 50);
        check("bp_req1_data", 32'(bus.resp_data), 32'h04);
        @(posedge clk); #1;

        // Reset while an operation sits in WAIT.
        drive_req(0, 1'b1, 4'd4, 4'd4, 3'd0);
        bus.resp0_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.req0_ready && n < 50);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_alu_a", 32'(bus.alu_a), 0);
        check("midrst_alu_b", 32'(bus.alu_b), 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        c0 = 0;
        repeat (5) begin
            @(negedge clk);
            c0 += int'(bus.resp0_valid);
            @(posedge clk); #1;
        end
        check("midrst_no_resp0", 32'(c0), 0);
        run_op(1, 4'd3, 4'd5, 3'b001, d, f, lat);
        check("sub_data", 32'(d), 32'hFE);
        check("sub_flags", 32'(f), 32'b0001);
        check("sub_latency", 32'(lat), 3);

        // Randomized traffic; the model checks every cycle.
        done = 0;
        for (int cyc = 0; cyc < 4000 && done < 150; cyc++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            done += int'(a0) + int'(a1);
            @(posedge clk); #1;
            if (!bus.req0_valid || a0) begin
                drive_req(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid || a1) begin
                drive_req(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.resp0_ready = ($urandom_range(0, 3) != 0);
            bus.resp1_ready = ($urandom_range(0, 3) != 0);
        end
        check("random_progress", 32'(done >= 150), 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
